// File: rtl/regfile_wb_scheduler_if.sv
// Writeback request bundle for regfile_wb_scheduler: two valid/ready requesters (ALU, load).
interface regfile_wb_scheduler_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic                  wb0_valid;
    logic                  wb0_ready;
    logic [ADDR_WIDTH-1:0] wb0_reg;
    logic [DATA_WIDTH-1:0] wb0_data;
    logic                  wb1_valid;
    logic                  wb1_ready;
    logic [ADDR_WIDTH-1:0] wb1_reg;
    logic [DATA_WIDTH-1:0] wb1_data;

    modport master (
        output wb0_valid, wb0_reg, wb0_data,
        output wb1_valid, wb1_reg, wb1_data,
        input  wb0_ready, wb1_ready
    );

    modport slave (
        input  wb0_valid, wb0_reg, wb0_data,
        input  wb1_valid, wb1_reg, wb1_data,
        output wb0_ready, wb1_ready
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates ALU/load writebacks onto the register file write port and tracks pending writes.
// Define REGWB_FIXED_PRIO_EN to give wb1 (load) fixed priority instead of round-robin.
module regfile_wb_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           iss_valid,
    input  logic [ADDR_WIDTH-1:0]          iss_reg,
    regfile_wb_scheduler_if.slave          wb,
    output logic                           RegWrite,
    output logic [ADDR_WIDTH-1:0]          WriteRegister,
    output logic [DATA_WIDTH-1:0]          WriteData,
    input  logic [ADDR_WIDTH-1:0]          ReadRegister1,
    input  logic [ADDR_WIDTH-1:0]          ReadRegister2,
    output logic                           hazard1,
    output logic                           hazard2,
    output logic [(1<<ADDR_WIDTH)-1:0]     pending
);
    localparam logic [ADDR_WIDTH-1:0] ZREG = ADDR_WIDTH'(ZERO_REG);

    logic                         grant0;
    logic                         grant1;
    logic                         xfer;
    logic [ADDR_WIDTH-1:0]        sel_reg;
    logic [DATA_WIDTH-1:0]        sel_data;
    logic [(1<<ADDR_WIDTH)-1:0]   pending_next;

`ifdef REGWB_FIXED_PRIO_EN
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset_n) begin
            if (wb.wb1_valid)      grant1 = 1'b1;
            else if (wb.wb0_valid) grant0 = 1'b1;
        end
    end
`else
    typedef enum logic {PREF_WB0, PREF_WB1} pref_t;
    pref_t pref;
    pref_t pref_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pref <= PREF_WB0;
        else          pref <= pref_next;
    end

    // Grants are gated by reset_n so neither ready can rise while reset is held.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        pref_next = pref;
        if (reset_n) begin
            if (wb.wb0_valid && wb.wb1_valid) begin
                if (pref == PREF_WB0) grant0 = 1'b1;
                else                  grant1 = 1'b1;
            end else begin
                grant0 = wb.wb0_valid;
                grant1 = wb.wb1_valid;
            end
        end
        if (grant0) pref_next = PREF_WB1;
        if (grant1) pref_next = PREF_WB0;
    end
`endif

    assign wb.wb0_ready = grant0;
    assign wb.wb1_ready = grant1;
    assign xfer     = grant0 | grant1;
    assign sel_reg  = grant1 ? wb.wb1_reg  : wb.wb0_reg;
    assign sel_data = grant1 ? wb.wb1_data : wb.wb0_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (xfer && sel_reg != ZREG) begin
                RegWrite      <= 1'b1;
                WriteRegister <= sel_reg;
                WriteData     <= sel_data;
            end
        end
    end

    // Issue is applied after commit so a same-edge set on the same register wins.
    always_comb begin
        pending_next = pending;
        if (RegWrite) pending_next[WriteRegister] = 1'b0;
        if (iss_valid && iss_reg != ZREG) pending_next[iss_reg] = 1'b1;
        pending_next[ZREG] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= pending_next;
    end

    assign hazard1 = (ReadRegister1 != ZREG) && pending[ReadRegister1];
    assign hazard2 = (ReadRegister2 != ZREG) && pending[ReadRegister2];
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus random traffic vs a behavioural model.
module tb_regfile_wb_scheduler;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] pending;

    int tests = 0;
    int fails = 0;

    regfile_wb_scheduler_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) wb_if ();

    regfile_wb_scheduler #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31)) dut (
        .clk(clk), .reset_n(reset_n),
        .iss_valid(iss_valid), .iss_reg(iss_reg),
        .wb(wb_if),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .hazard1(hazard1), .hazard2(hazard2), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending set, who was granted last, and what the write port must show.
    logic [31:0] m_pend;
    bit          m_last_wb0;
    bit          m_rw;
    logic [4:0]  m_wr;
    logic [63:0] m_wd;
    bit          m_known;

    initial begin
        bit e0, e1, v0, v1;
        logic [4:0]  r;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_pend = '0; m_last_wb0 = 1'b0; m_rw = 1'b0;
                m_wr = '0; m_wd = '0; m_known = 1'b1;
                chk("m_rst_rdy0", {63'd0, wb_if.wb0_ready}, 64'd0);
                chk("m_rst_rdy1", {63'd0, wb_if.wb1_ready}, 64'd0);
                chk("m_rst_rw", {63'd0, RegWrite}, 64'd0);
                chk("m_rst_pend", {32'd0, pending}, 64'd0);
            end else begin
                v0 = wb_if.wb0_valid;
                v1 = wb_if.wb1_valid;
`ifdef REGWB_FIXED_PRIO_EN
                e1 = v1;
                e0 = v0 && !v1;
`else
                e0 = v0 && (!v1 || !m_last_wb0);
                e1 = v1 && (!v0 || m_last_wb0);
`endif
                chk("m_rdy0", {63'd0, wb_if.wb0_ready}, {63'd0, e0});
                chk("m_rdy1", {63'd0, wb_if.wb1_ready}, {63'd0, e1});
                chk("m_rw", {63'd0, RegWrite}, {63'd0, m_rw});
                if (m_rw || m_known) begin
                    chk("m_wr", {59'd0, WriteRegister}, {59'd0, m_wr});
                    chk("m_wd", WriteData, m_wd);
                end
                chk("m_pend", {32'd0, pending}, {32'd0, m_pend});
                chk("m_haz1", {63'd0, hazard1},
                    {63'd0, (ReadRegister1 != 5'd31) && m_pend[ReadRegister1]});
                chk("m_haz2", {63'd0, hazard2},
                    {63'd0, (ReadRegister2 != 5'd31) && m_pend[ReadRegister2]});
                // Advance the model to the state after the coming posedge.
                if (m_rw) m_pend[m_wr] = 1'b0;
                if (iss_valid && iss_reg != 5'd31) m_pend[iss_reg] = 1'b1;
                m_rw = 1'b0;
                if (e0 || e1) begin
                    r = e1 ? wb_if.wb1_reg  : wb_if.wb0_reg;
                    d = e1 ? wb_if.wb1_data : wb_if.wb0_data;
                    m_last_wb0 = e0;
                    if (r != 5'd31) begin
                        m_rw = 1'b1; m_wr = r; m_wd = d; m_known = 1'b1;
                    end else begin
                        m_known = 1'b0;
                    end
                end
            end
        end
    end

    task automatic idle();
        wb_if.wb0_valid = 1'b0; wb_if.wb1_valid = 1'b0;
        wb_if.wb0_reg = '0; wb_if.wb1_reg = '0;
        wb_if.wb0_data = '0; wb_if.wb1_data = '0;
        iss_valid = 1'b0; iss_reg = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        if ($urandom_range(0, 4) == 0) return 5'd31;
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        reset_n = 1'b0;
        wb_if.wb0_valid = 1'b1;
        wb_if.wb0_reg = 5'd5;
        #3;
        chk("rst_ready", {63'd0, wb_if.wb0_ready}, 64'd0);
        chk("rst_regwrite", {63'd0, RegWrite}, 64'd0);
        chk("rst_wreg", {59'd0, WriteRegister}, 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_pending", {32'd0, pending}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();

        // Single ALU writeback.
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd5; wb_if.wb0_data = 64'hDEAD;
        #2;
        chk("single_rdy0", {63'd0, wb_if.wb0_ready}, 64'd1);
        chk("single_rdy1", {63'd0, wb_if.wb1_ready}, 64'd0);
        cyc(); idle();
        #2;
        chk("single_rw", {63'd0, RegWrite}, 64'd1);
        chk("single_wr", {59'd0, WriteRegister}, 64'd5);
        chk("single_wd", WriteData, 64'hDEAD);
        cyc();
        #2;
        chk("single_rw_off", {63'd0, RegWrite}, 64'd0);

        // Lone wb1 grant brings the round-robin preference back to wb0.
        wb_if.wb1_valid = 1'b1; wb_if.wb1_reg = 5'd4; wb_if.wb1_data = 64'h44;
        cyc(); idle();

        // Both requesters held valid for four cycles.
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd1; wb_if.wb0_data = 64'h11;
        wb_if.wb1_valid = 1'b1; wb_if.wb1_reg = 5'd2; wb_if.wb1_data = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #2;
`ifdef REGWB_FIXED_PRIO_EN
            chk("arb_rdy0", {63'd0, wb_if.wb0_ready}, 64'd0);
            chk("arb_rdy1", {63'd0, wb_if.wb1_ready}, 64'd1);
`else
            chk("arb_rdy0", {63'd0, wb_if.wb0_ready}, (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("arb_rdy1", {63'd0, wb_if.wb1_ready}, (i % 2 == 0) ? 64'd0 : 64'd1);
`endif
            cyc();
        end
        idle();
        cyc();

        // Hazard on reg 7 lasts through its RegWrite cycle.
        ReadRegister1 = 5'd7;
        iss_valid = 1'b1; iss_reg = 5'd7;
        cyc(); idle();
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd7; wb_if.wb0_data = 64'h77;
        #2;
        chk("haz_issued", {63'd0, hazard1}, 64'd1);
        cyc(); idle();
        #2;
        chk("haz_rw", {63'd0, RegWrite}, 64'd1);
        chk("haz_during_rw", {63'd0, hazard1}, 64'd1);
        cyc();
        #2;
        chk("haz_cleared", {63'd0, hazard1}, 64'd0);

        // Zero register: handshake completes, nothing written or tracked.
        ReadRegister2 = 5'd31;
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd31; wb_if.wb0_data = 64'h3131;
        iss_valid = 1'b1; iss_reg = 5'd31;
        #2;
        chk("zero_rdy0", {63'd0, wb_if.wb0_ready}, 64'd1);
        cyc(); idle();
        #2;
        chk("zero_rw", {63'd0, RegWrite}, 64'd0);
        chk("zero_pend31", {63'd0, pending[31]}, 64'd0);
        chk("zero_haz2", {63'd0, hazard2}, 64'd0);

        // Issue of reg 9 on the same edge as its commit keeps it pending.
        iss_valid = 1'b1; iss_reg = 5'd9;
        cyc(); idle();
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd9; wb_if.wb0_data = 64'h99;
        cyc(); idle();
        iss_valid = 1'b1; iss_reg = 5'd9;
        #2;
        chk("same_edge_rw", {63'd0, RegWrite}, 64'd1);
        chk("same_edge_wr", {59'd0, WriteRegister}, 64'd9);
        cyc(); idle();
        #2;
        chk("same_edge_pend9", {63'd0, pending[9]}, 64'd1);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            cyc();
            wb_if.wb0_valid = ($urandom_range(0, 1) == 1);
            wb_if.wb1_valid = ($urandom_range(0, 1) == 1);
            wb_if.wb0_reg   = rnd_reg();
            wb_if.wb1_reg   = rnd_reg();
            wb_if.wb0_data  = {$urandom, $urandom};
            wb_if.wb1_data  = {$urandom, $urandom};
            iss_valid       = ($urandom_range(0, 2) == 0);
            iss_reg         = rnd_reg();
            ReadRegister1   = rnd_reg();
            ReadRegister2   = rnd_reg();
        end
        cyc(); idle();
        cyc();

        // Asynchronous reset in the middle of a RegWrite cycle.
        iss_valid = 1'b1; iss_reg = 5'd3;
        cyc(); idle();
        wb_if.wb0_valid = 1'b1; wb_if.wb0_reg = 5'd3; wb_if.wb0_data = 64'h33;
        cyc(); idle();
        chk("pre_rst_rw", {63'd0, RegWrite}, 64'd1);
        chk("pre_rst_pend3", {63'd0, pending[3]}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_rw", {63'd0, RegWrite}, 64'd0);
        chk("midrst_pend", {32'd0, pending}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
